// File: rtl/pe_inject_arbiter.sv
// pe_inject_arbiter: shares one PE flit injection port among NUM_REQ sources.
// A round-robin grant is issued only when the target VC has a downstream credit.
// A head flit without tail locks the port to its requester until the tail (wormhole).
// The block also keeps the per-VC credit counters fed by credit_in.
module pe_inject_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned NUM_VCS         = 2,
    parameter int unsigned DEST_BITS       = 4,
    parameter int unsigned FLIT_DATA_WIDTH = 64,
    parameter int unsigned BUF_DEPTH       = 4,
    localparam int unsigned VC_BITS = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int unsigned FLIT_W  = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_tail,
    input  logic [NUM_REQ*DEST_BITS-1:0]         req_dest,
    input  logic [NUM_REQ*VC_BITS-1:0]           req_vc,
    input  logic [NUM_REQ*FLIT_DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [FLIT_W-1:0]                    flit_out,
    output logic                                 sendFlit,
    input  logic [VC_BITS:0]                     credit_in,
    output logic                                 locked,
    output logic                                 credit_err
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {StIdle, StLocked} state_e;

    state_e                 state_q;
    logic [ID_W-1:0]        ptr_q;
    logic [ID_W-1:0]        lock_id_q;
    logic [VC_BITS-1:0]     lock_vc_q;
    logic [CNT_W-1:0]       cnt_q [NUM_VCS];

    logic                       accept;
    logic [ID_W-1:0]            grant_id;
    logic [ID_W:0]              sum;
    logic [ID_W-1:0]            idx;
    logic [VC_BITS-1:0]         cand_vc;
    logic                       acc_tail;
    logic [DEST_BITS-1:0]       acc_dest;
    logic [VC_BITS-1:0]         acc_vc;
    logic [FLIT_DATA_WIDTH-1:0] acc_data;
    logic [ID_W-1:0]            next_ptr;
    logic [NUM_VCS-1:0]         inc_vec;
    logic [NUM_VCS-1:0]         dec_vec;

    assign locked = (state_q == StLocked);

    // Grant selection: lock holder only when locked, else round-robin from ptr_q.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        grant_id  = '0;
        sum       = '0;
        idx       = '0;
        cand_vc   = '0;
        if (!rst && en) begin
            if (state_q == StLocked) begin
                if (req_valid[lock_id_q] && (cnt_q[lock_vc_q] != '0)) begin
                    accept   = 1'b1;
                    grant_id = lock_id_q;
                end
            end else begin
                for (int unsigned off = 0; off < NUM_REQ; off++) begin
                    sum = {1'b0, ptr_q} + (ID_W+1)'(off);
                    if (sum >= (ID_W+1)'(NUM_REQ)) begin
                        sum = sum - (ID_W+1)'(NUM_REQ);
                    end
                    idx     = sum[ID_W-1:0];
                    cand_vc = req_vc[idx*VC_BITS +: VC_BITS];
                    if (!accept && req_valid[idx] && (cnt_q[cand_vc] != '0)) begin
                        accept   = 1'b1;
                        grant_id = idx;
                    end
                end
            end
        end
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Fields of the accepted flit; body flits reuse the VC captured at the head.
    assign acc_tail = req_tail[grant_id];
    assign acc_dest = req_dest[grant_id*DEST_BITS +: DEST_BITS];
    assign acc_data = req_data[grant_id*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
    assign acc_vc   = (state_q == StLocked) ? lock_vc_q : req_vc[grant_id*VC_BITS +: VC_BITS];
    assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Per-VC consume/return strobes for the counter update.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            inc_vec[v] = credit_in[VC_BITS] && (credit_in[VC_BITS-1:0] == VC_BITS'(v));
            dec_vec[v] = accept && (acc_vc == VC_BITS'(v));
        end
    end

    // Wormhole FSM plus registered flit output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            lock_id_q <= '0;
            lock_vc_q <= '0;
            flit_out  <= '0;
            sendFlit  <= 1'b0;
        end else begin
            sendFlit <= accept;
            flit_out <= accept ? {1'b1, acc_tail, acc_dest, acc_vc, acc_data} : '0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        ptr_q <= next_ptr;
                        if (!acc_tail) begin
                            state_q   <= StLocked;
                            lock_id_q <= grant_id;
                            lock_vc_q <= acc_vc;
                        end
                    end
                end
                StLocked: begin
                    // ptr_q already points past the lock holder from the head grant.
                    if (accept && acc_tail) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Credit counters; a return into a full counter is dropped and flagged sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned v = 0; v < NUM_VCS; v++) begin
                cnt_q[v] <= CNT_W'(BUF_DEPTH);
            end
            credit_err <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < NUM_VCS; v++) begin
                if (inc_vec[v] && !dec_vec[v]) begin
                    if (cnt_q[v] == CNT_W'(BUF_DEPTH)) begin
                        credit_err <= 1'b1;
                    end else begin
                        cnt_q[v] <= cnt_q[v] + 1'b1;
                    end
                end else if (dec_vec[v] && !inc_vec[v]) begin
                    cnt_q[v] <= cnt_q[v] - 1'b1;
                end
            end
        end
    end

endmodule
